// File: rtl/qrd_pkg.sv
// Shared constants, state encoding and schedule step numbers for the QRD sequencer.
package qrd_pkg;

    localparam int N         = 4;
    localparam int IN_W      = 14;
    localparam int FRAC_BITS = 10;

    // Fixed-point 1.0 used for the identity augmentation columns
    localparam logic [IN_W-1:0] ONE = IN_W'(1 << FRAC_BITS);

    // Core schedule: R rows emerge from step 5, QH rows from step 9 (row 0 timing)
    localparam logic [3:0] R_START    = 4'd5;
    localparam logic [3:0] QH_START   = 4'd9;
    localparam logic [3:0] LAST_STEP  = 4'd15;
    localparam logic [3:0] FLAG1_STEP = 4'd0;
    localparam logic [3:0] FLAG2_STEP = 4'd2;
    localparam logic [3:0] FLAG3_STEP = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_UNLOAD
    } state_t;

endpackage

// File: rtl/qrd_mat_buf.sv
// 4x4 complex register file: one write port per row, combinational read per row.
// A single-element writer (H) enables only one row; R/QH capture uses all rows at once.
module qrd_mat_buf
    import qrd_pkg::*;
(
    input  logic                      clk,
    input  logic [N-1:0]              wr_en,
    input  logic [N-1:0][1:0]         wr_col,
    input  logic [N-1:0][IN_W-1:0]    wr_r,
    input  logic [N-1:0][IN_W-1:0]    wr_i,
    input  logic [N-1:0][1:0]         rd_col,
    output logic [N-1:0][IN_W-1:0]    rd_r,
    output logic [N-1:0][IN_W-1:0]    rd_i
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            logic [IN_W-1:0] mem_r_q [N];
            logic [IN_W-1:0] mem_i_q [N];

            // Row storage is deliberately not reset: contents survive a sequencer reset
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem_r_q[wr_col[gi]] <= wr_r[gi];
                    mem_i_q[wr_col[gi]] <= wr_i[gi];
                end
            end

            assign rd_r[gi] = mem_r_q[rd_col[gi]];
            assign rd_i[gi] = mem_i_q[rd_col[gi]];
        end
    endgenerate

endmodule

// File: rtl/qrd_seq_ctrl.sv
// Sequencer: buffers one H matrix, feeds the QRD core its skewed row schedule,
// captures skewed R / QH rows and streams them out row-major (R first, then QH).
module qrd_seq_ctrl
    import qrd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            h_valid,
    output logic            h_ready,
    input  logic [IN_W-1:0] h_r,
    input  logic [IN_W-1:0] h_i,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [IN_W-1:0] o_r,
    output logic [IN_W-1:0] o_i,
    output logic            o_is_qh,
    output logic            o_last,
    output logic            busy,
    output logic [IN_W-1:0] qrd_row_in_1_r,
    output logic [IN_W-1:0] qrd_row_in_1_i,
    output logic [IN_W-1:0] qrd_row_in_2_r,
    output logic [IN_W-1:0] qrd_row_in_2_i,
    output logic [IN_W-1:0] qrd_row_in_3_r,
    output logic [IN_W-1:0] qrd_row_in_3_i,
    output logic [IN_W-1:0] qrd_row_in_4_r,
    output logic [IN_W-1:0] qrd_row_in_4_i,
    output logic            qrd_row_in_1_f,
    output logic            qrd_row_in_2_f,
    output logic            qrd_row_in_3_f,
    input  logic            qrd_in_ready,
    input  logic            qrd_out_valid,
    input  logic [IN_W-1:0] qrd_row_out_1_r,
    input  logic [IN_W-1:0] qrd_row_out_1_i,
    input  logic [IN_W-1:0] qrd_row_out_2_r,
    input  logic [IN_W-1:0] qrd_row_out_2_i,
    input  logic [IN_W-1:0] qrd_row_out_3_r,
    input  logic [IN_W-1:0] qrd_row_out_3_i,
    input  logic [IN_W-1:0] qrd_row_out_4_r,
    input  logic [IN_W-1:0] qrd_row_out_4_i
);

    state_t                   state_q, state_d;
    logic [3:0]               e_q, e_d;          // load element counter
    logic [3:0]               l_q, l_d;          // feed step counter
    logic [4:0]               c_q, c_d;          // unload element counter
    logic [N-1:0][IN_W-1:0]   cin_r_q, cin_r_d;
    logic [N-1:0][IN_W-1:0]   cin_i_q, cin_i_d;
    logic [2:0]               flag_q, flag_d;
    logic                     o_valid_q, o_valid_d;
    logic [IN_W-1:0]          o_r_q, o_r_d;
    logic [IN_W-1:0]          o_i_q, o_i_d;
    logic                     o_is_qh_q, o_is_qh_d;
    logic                     o_last_q, o_last_d;

    // Buffer port wiring
    logic [N-1:0]             h_wr_en, r_wr_en, qh_wr_en;
    logic [N-1:0][1:0]        h_wr_col, r_wr_col, qh_wr_col;
    logic [N-1:0][1:0]        h_rd_col, out_rd_col;
    logic [N-1:0][IN_W-1:0]   h_rd_r, h_rd_i, r_rd_r, r_rd_i, qh_rd_r, qh_rd_i;
    logic [N-1:0][IN_W-1:0]   cout_r, cout_i;

    // Per-row schedule helpers
    logic [N-1:0][4:0]        feed_idx, r_rel, qh_rel;
    logic [N-1:0][IN_W-1:0]   step_r, step_i;

    logic                     feed_cap;
    logic [4:0]               n_idx;             // index of the element to present next
    logic [IN_W-1:0]          sel_r, sel_i;

    assign cout_r = {qrd_row_out_4_r, qrd_row_out_3_r, qrd_row_out_2_r, qrd_row_out_1_r};
    assign cout_i = {qrd_row_out_4_i, qrd_row_out_3_i, qrd_row_out_2_i, qrd_row_out_1_i};

    assign feed_cap = (state_q == ST_FEED) && qrd_out_valid;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sched
            // H load: row-major element e lands in row e[3:2], column e[1:0]
            assign h_wr_en[gi]  = (state_q == ST_LOAD) && h_valid && (e_q[3:2] == 2'(gi));
            assign h_wr_col[gi] = e_q[1:0];

            // Row gi is delayed by gi steps; idx 0..3 is H, 4..7 identity, else zero
            assign feed_idx[gi] = {1'b0, l_q} - 5'(gi);
            assign h_rd_col[gi] = feed_idx[gi][1:0];
            assign step_r[gi]   = (feed_idx[gi][4] || feed_idx[gi][3]) ? '0 :
                                  (!feed_idx[gi][2]) ? h_rd_r[gi] :
                                  (feed_idx[gi][1:0] == 2'(gi)) ? ONE : '0;
            assign step_i[gi]   = (!feed_idx[gi][4] && !feed_idx[gi][3] && !feed_idx[gi][2])
                                  ? h_rd_i[gi] : '0;

            // Capture windows: unsigned wrap makes "below window" fail the < 4 test
            assign r_rel[gi]     = {1'b0, l_q} - (5'(R_START) + 5'(gi));
            assign qh_rel[gi]    = {1'b0, l_q} - (5'(QH_START) + 5'(gi));
            assign r_wr_en[gi]   = feed_cap && (r_rel[gi] < 5'd4);
            assign qh_wr_en[gi]  = feed_cap && (qh_rel[gi] < 5'd4);
            assign r_wr_col[gi]  = r_rel[gi][1:0];
            assign qh_wr_col[gi] = qh_rel[gi][1:0];
        end
    endgenerate

    // Readout: all rows read the same column, the row is then selected here
    assign n_idx      = (state_q == ST_UNLOAD) ? (c_q + 5'd1) : 5'd0;
    assign out_rd_col = {N{n_idx[1:0]}};
    assign sel_r      = n_idx[4] ? qh_rd_r[n_idx[3:2]] : r_rd_r[n_idx[3:2]];
    assign sel_i      = n_idx[4] ? qh_rd_i[n_idx[3:2]] : r_rd_i[n_idx[3:2]];

    qrd_mat_buf u_h_buf (
        .clk    (clk),
        .wr_en  (h_wr_en),
        .wr_col (h_wr_col),
        .wr_r   ({N{h_r}}),
        .wr_i   ({N{h_i}}),
        .rd_col (h_rd_col),
        .rd_r   (h_rd_r),
        .rd_i   (h_rd_i)
    );

    qrd_mat_buf u_r_buf (
        .clk    (clk),
        .wr_en  (r_wr_en),
        .wr_col (r_wr_col),
        .wr_r   (cout_r),
        .wr_i   (cout_i),
        .rd_col (out_rd_col),
        .rd_r   (r_rd_r),
        .rd_i   (r_rd_i)
    );

    qrd_mat_buf u_qh_buf (
        .clk    (clk),
        .wr_en  (qh_wr_en),
        .wr_col (qh_wr_col),
        .wr_r   (cout_r),
        .wr_i   (cout_i),
        .rd_col (out_rd_col),
        .rd_r   (qh_rd_r),
        .rd_i   (qh_rd_i)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        l_d       = l_q;
        c_d       = c_q;
        cin_r_d   = cin_r_q;
        cin_i_d   = cin_i_q;
        flag_d    = flag_q;
        o_valid_d = o_valid_q;
        o_r_d     = o_r_q;
        o_i_d     = o_i_q;
        o_is_qh_d = o_is_qh_q;
        o_last_d  = o_last_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                e_d     = 4'd0;
            end
            ST_LOAD: begin
                if (h_valid) begin
                    e_d = e_q + 4'd1;
                    if (e_q == 4'd15) begin
                        state_d = ST_FEED;
                        l_d     = 4'd0;
                    end
                end
            end
            ST_FEED: begin
                if (l_q == LAST_STEP) begin
                    // Schedule exhausted: flush the core inputs and wait for its results
                    cin_r_d = '0;
                    cin_i_d = '0;
                    flag_d  = '0;
                    if (qrd_out_valid) begin
                        state_d   = ST_UNLOAD;
                        c_d       = 5'd0;
                        o_valid_d = 1'b1;
                        o_r_d     = sel_r;
                        o_i_d     = sel_i;
                        o_is_qh_d = n_idx[4];
                        o_last_d  = (n_idx == 5'd31);
                    end
                end else if (qrd_in_ready) begin
                    cin_r_d = step_r;
                    cin_i_d = step_i;
                    flag_d  = {l_q == FLAG3_STEP, l_q == FLAG2_STEP, l_q == FLAG1_STEP};
                    l_d     = l_q + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (o_valid_q && o_ready) begin
                    if (c_q == 5'd31) begin
                        state_d   = ST_IDLE;
                        c_d       = 5'd0;
                        o_valid_d = 1'b0;
                        o_r_d     = '0;
                        o_i_d     = '0;
                        o_is_qh_d = 1'b0;
                        o_last_d  = 1'b0;
                    end else begin
                        c_d       = c_q + 5'd1;
                        o_r_d     = sel_r;
                        o_i_d     = sel_i;
                        o_is_qh_d = n_idx[4];
                        o_last_d  = (n_idx == 5'd31);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            e_q       <= '0;
            l_q       <= '0;
            c_q       <= '0;
            cin_r_q   <= '0;
            cin_i_q   <= '0;
            flag_q    <= '0;
            o_valid_q <= 1'b0;
            o_r_q     <= '0;
            o_i_q     <= '0;
            o_is_qh_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            l_q       <= l_d;
            c_q       <= c_d;
            cin_r_q   <= cin_r_d;
            cin_i_q   <= cin_i_d;
            flag_q    <= flag_d;
            o_valid_q <= o_valid_d;
            o_r_q     <= o_r_d;
            o_i_q     <= o_i_d;
            o_is_qh_q <= o_is_qh_d;
            o_last_q  <= o_last_d;
        end
    end

    assign h_ready = (state_q == ST_LOAD);
    assign busy    = (state_q != ST_IDLE);
    assign o_valid = o_valid_q;
    assign o_r     = o_r_q;
    assign o_i     = o_i_q;
    assign o_is_qh = o_is_qh_q;
    assign o_last  = o_last_q;

    assign qrd_row_in_1_r = cin_r_q[0];
    assign qrd_row_in_1_i = cin_i_q[0];
    assign qrd_row_in_2_r = cin_r_q[1];
    assign qrd_row_in_2_i = cin_i_q[1];
    assign qrd_row_in_3_r = cin_r_q[2];
    assign qrd_row_in_3_i = cin_i_q[2];
    assign qrd_row_in_4_r = cin_r_q[3];
    assign qrd_row_in_4_i = cin_i_q[3];
    assign qrd_row_in_1_f = flag_q[0];
    assign qrd_row_in_2_f = flag_q[1];
    assign qrd_row_in_3_f = flag_q[2];

endmodule
